// File: rtl/systolic_feed_ctrl.sv
// systolic_feed_ctrl: feeds one tile of skewed feature vectors into a systolic array.
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     begin a tile (only honoured in IDLE)
//   abort     synchronous abort, beats every other input
//   in_valid  in_data valid
//   in_ready  vector accepted this cycle when in_valid is also high
//   in_data   one vector, slice [r*N +: N] feeds row r
//   f_out     skewed array inputs, slice r drives array row r
//   arr_en    array step enable, high when f_out carries a new step
//   arr_clr   clear array accumulators
//   busy      controller not idle
//   done      one-cycle pulse once the array holds the final tile result
//   vec_cnt   vectors accepted in the current tile
module systolic_feed_ctrl #(
    parameter int N        = 8,
    parameter int ROWS     = 8,
    parameter int TILE_LEN = 8,
    parameter int PIPE_LAT = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic                              abort,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [ROWS*N-1:0]                 in_data,
    output logic [ROWS*N-1:0]                 f_out,
    output logic                              arr_en,
    output logic                              arr_clr,
    output logic                              busy,
    output logic                              done,
    output logic [$clog2(TILE_LEN+1)-1:0]     vec_cnt
);
    localparam int VW = $clog2(TILE_LEN+1);
    localparam int DL = ROWS - 1 + PIPE_LAT;
    localparam int DW = $clog2(DL + 1);
    localparam logic [VW-1:0] LAST_VEC = VW'(TILE_LEN - 1);
    localparam logic [DW-1:0] LAST_DRN = DW'(DL - 1);

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, SETTLE, DONE} state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] dcnt;
    logic          accept, adv;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        arr_clr   = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        adv       = 1'b0;
        case (state)
            IDLE:   state_nxt = start ? CLEAR : IDLE;
            CLEAR: begin
                arr_clr   = 1'b1;
                state_nxt = FEED;
            end
            FEED: begin
                in_ready  = 1'b1;
                accept    = in_valid;
                adv       = in_valid;
                state_nxt = (in_valid && vec_cnt == LAST_VEC) ? DRAIN : FEED;
            end
            DRAIN: begin
                adv       = 1'b1;
                state_nxt = (dcnt == LAST_DRN) ? SETTLE : DRAIN;
            end
            SETTLE: state_nxt = DONE;
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Abort suppresses the handshake so no vector is lost half-accepted.
        if (abort) begin
            state_nxt = IDLE;
            in_ready  = 1'b0;
            accept    = 1'b0;
            adv       = 1'b0;
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            vec_cnt <= '0;
            dcnt    <= '0;
            arr_en  <= 1'b0;
        end else begin
            arr_en  <= adv;
            vec_cnt <= (abort || state == CLEAR) ? '0 : accept ? vec_cnt + 1'b1 : vec_cnt;
            dcnt    <= (abort || state != DRAIN) ? '0 : dcnt + 1'b1;
        end

    // Row r: sr[0..r-1] is the r-deep delay line, sr[r] is the f_out register.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic [N-1:0] sr [0:r];
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) begin
                for (int k = 0; k <= r; k++) sr[k] <= '0;
            end else if (abort) begin
                for (int k = 0; k <= r; k++) sr[k] <= '0;
            end else if (adv) begin
                sr[0] <= (state == FEED) ? in_data[r*N +: N] : '0;
                for (int k = 1; k <= r; k++) sr[k] <= sr[k-1];
            end
        assign f_out[r*N +: N] = sr[r];
    end
endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// tb_systolic_feed_ctrl: directed table and sequence checks for systolic_feed_ctrl.
module tb_systolic_feed_ctrl;
    localparam int N = 8, ROWS = 8, TL = 8, PL = 2;
    localparam int AEN = TL + ROWS - 1 + PL;
    localparam logic H = 1'b1, L = 1'b0;

    logic              clk = 1'b0, rst_n = 1'b0;
    logic              start = 1'b0, abort = 1'b0, in_valid = 1'b0;
    logic [ROWS*N-1:0] in_data = '0;
    logic              in_ready, arr_en, arr_clr, busy, done;
    logic [ROWS*N-1:0] f_out;
    logic [3:0]        vec_cnt;

    int tests = 0, fails = 0;

    systolic_feed_ctrl #(.N(N), .ROWS(ROWS), .TILE_LEN(TL), .PIPE_LAT(PL)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .f_out(f_out), .arr_en(arr_en), .arr_clr(arr_clr), .busy(busy),
        .done(done), .vec_cnt(vec_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       st, vl;
        logic [7:0] d;
        logic       rdy, en, clr, bsy, dn;
        logic [3:0] cnt;
        int         a;
    } vec_t;

    vec_t tbl [21];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [ROWS*N-1:0] vec(input int k);
        logic [ROWS*N-1:0] v;
        for (int r = 0; r < ROWS; r++) v[r*N +: N] = 8'(k);
        return v;
    endfunction

    // After the a-th advance row r holds vector a-r, or zero outside 1..TL.
    function automatic logic [ROWS*N-1:0] exp_f(input int a);
        logic [ROWS*N-1:0] v;
        for (int r = 0; r < ROWS; r++) v[r*N +: N] = (a - r >= 1 && a - r <= TL) ? 8'(a - r) : 8'd0;
        return v;
    endfunction

    task automatic run_tile(input int bub_at, input int bub_len, input bit noise);
        int sent = 0, a = 0, low = 0, bub = 0;
        bit fin = 0, last_en = 0;
        logic acc;
        logic [63:0] prev = '0;
        start = 1'b1;
        in_valid = 1'b0;
        step();
        start = 1'b0;
        for (int c = 0; c < 80 && !fin; c++) begin
            if (in_ready && sent == bub_at && bub < bub_len) begin
                in_valid = 1'b0;
                bub++;
            end else in_valid = in_ready && sent < TL;
            in_data = vec(sent + 1);
            start = noise & in_ready;
            acc = in_valid & in_ready;
            step();
            if (acc) sent++;
            if (arr_en) begin
                a++;
                chk("skew", f_out, exp_f(a));
            end else begin
                chk("hold", f_out, prev);
                if (a > 0 && a < AEN) low++;
            end
            prev = f_out;
            if (done) begin
                fin = 1;
                chk("en_total", 64'(a), 64'(AEN));
                chk("done_after_en", 64'(last_en), 64'(1));
                chk("vec_cnt_done", 64'(vec_cnt), 64'(TL));
            end
            last_en = arr_en;
        end
        start = 1'b0;
        in_valid = 1'b0;
        chk("done_seen", 64'(fin), 64'(1));
        chk("bubble_low", 64'(low), 64'(bub_len));
    endtask

    task automatic feed_n(input int n);
        int sent = 0;
        logic acc;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 40 && sent < n; c++) begin
            in_valid = 1'b1;
            in_data = vec(sent + 1);
            acc = in_ready;
            step();
            if (acc) sent++;
        end
        in_valid = 1'b0;
        chk("feed_count", 64'(sent), 64'(n));
    endtask

    initial begin
        tbl[0] = '{H, L, 8'd0, L, L, H, H, L, 4'd0, 0};
        tbl[1] = '{L, H, 8'd1, H, L, L, H, L, 4'd0, 0};
        for (int k = 1; k <= TL; k++) tbl[k+1] = '{L, H, 8'(k), (k < TL), H, L, H, L, 4'(k), k};
        for (int a = TL + 1; a <= AEN; a++) tbl[a+1] = '{L, L, 8'd0, L, H, L, H, L, 4'(TL), a};
        tbl[19] = '{L, L, 8'd0, L, L, L, H, H, 4'(TL), AEN};
        tbl[20] = '{L, L, 8'd0, L, L, L, L, L, 4'(TL), AEN};

        // Reset with random inputs
        for (int i = 0; i < 4; i++) begin
            start = 1'($urandom);
            abort = 1'($urandom);
            in_valid = 1'($urandom);
            in_data = {$urandom, $urandom};
            step();
            chk("rst_out", {f_out}, 64'd0);
            chk("rst_ctl", 64'({in_ready, arr_en, arr_clr, busy, done, vec_cnt}), 64'd0);
        end
        start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
        rst_n = 1'b1;
        step();

        // Continuous tile, cycle by cycle
        foreach (tbl[j]) begin
            start = tbl[j].st;
            in_valid = tbl[j].vl;
            in_data = vec(int'(tbl[j].d));
            step();
            chk($sformatf("t%0d_rdy", j), 64'(in_ready), 64'(tbl[j].rdy));
            chk($sformatf("t%0d_en", j), 64'(arr_en), 64'(tbl[j].en));
            chk($sformatf("t%0d_clr", j), 64'(arr_clr), 64'(tbl[j].clr));
            chk($sformatf("t%0d_busy", j), 64'(busy), 64'(tbl[j].bsy));
            chk($sformatf("t%0d_done", j), 64'(done), 64'(tbl[j].dn));
            chk($sformatf("t%0d_cnt", j), 64'(vec_cnt), 64'(tbl[j].cnt));
            chk($sformatf("t%0d_f", j), f_out, exp_f(tbl[j].a));
        end
        start = 1'b0; in_valid = 1'b0;

        // Bubbles after vector 4
        run_tile(4, 3, 1'b0);
        step();

        // Abort on the third drain cycle
        feed_n(TL);
        step();
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_f", f_out, 64'd0);
        chk("abort_en", 64'(arr_en), 64'd0);
        chk("abort_cnt", 64'(vec_cnt), 64'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("abort_no_done", 64'({done, arr_en}), 64'd0);
        end
        run_tile(0, 0, 1'b0);
        step();

        // Start and abort together in IDLE
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        chk("start_abort_idle", 64'(busy), 64'd0);

        // Start noise during FEED and DONE
        run_tile(0, 0, 1'b1);
        start = 1'b1;
        step();
        chk("done_start_ign", 64'({busy, done}), 64'd0);
        step();
        start = 1'b0;
        chk("restart_clr", 64'({arr_clr, busy}), 64'b11);
        run_tile(0, 0, 1'b0);
        step();

        // Async reset mid-feed
        feed_n(5);
        chk("pre_rst_cnt", 64'(vec_cnt), 64'd5);
        in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_f", f_out, 64'd0);
        chk("arst_ctl", 64'({in_ready, arr_en, arr_clr, busy, done, vec_cnt}), 64'd0);
        in_valid = 1'b0;
        step();
        chk("arst_hold", 64'({busy, done, arr_en}), 64'd0);
        rst_n = 1'b1;
        step();
        run_tile(0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
